// File: rtl/serial_add_sched.sv
// Two-client scheduler for a shared LSB-first bit-serial adder: arbitrates req/gnt, shifts WIDTH add cycles, returns sum/cout with done.
// Build option SERIAL_ADD_SCHED_RR_EN selects round-robin arbitration; left undefined, req0 has fixed priority over req1.
module serial_add_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, owner_q, owner_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             done_id_q, done_id_d, cout_q, cout_d;
    logic             win, s_bit, c_bit;

    // Handshake: a client holds req (level) with stable operands; the one-cycle
    // gnt pulse means its operands were captured and it must drop req now.
    // Requests are looked at only in IDLE, so a held req simply waits.
`ifdef SERIAL_ADD_SCHED_RR_EN
    logic last_q, last_d;

    assign win = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && (req0 || req1)) begin
            last_d = win;
        end
    end

    // Pointer at 1 lets client 0 take the first tie after reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win = ~req0;
`endif

    assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        busy_d    = busy_q;
        done_d    = done_q;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        case (state_q)
            S_IDLE: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b0;
                if (req0 || req1) begin
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    owner_d = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Sum bits refill A from the top, so A holds the full sum after WIDTH shifts.
                a_d     = {s_bit, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = c_bit;
                cnt_d   = cnt_q + 1'b1;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                if (cnt_q == LAST_BIT) begin
                    sum_d     = {s_bit, a_q[WIDTH-1:1]};
                    cout_d    = c_bit;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: WIDTH=4 and WIDTH=8 instances against an arithmetic reference model.
// Arbitration expectations follow SERIAL_ADD_SCHED_RR_EN when the bench is built with it.
module tb_serial_add_sched;
    localparam int W  = 4;
    localparam int W8 = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (WIDTH=4) ----------------
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, busy, done, done_id, cout;
    logic [W-1:0] sum;
    logic [1:0]   dbg_state;

    serial_add_sched #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
        .sum(sum), .cout(cout), .dbg_state(dbg_state)
    );

    // ---------------- DUT (WIDTH=8) ----------------
    logic          r8_req0 = 1'b0, r8_req1 = 1'b0;
    logic [W8-1:0] r8_a0 = '0, r8_b0 = '0, r8_a1 = '0, r8_b1 = '0;
    logic          r8_gnt0, r8_gnt1, r8_busy, r8_done, r8_done_id, r8_cout;
    logic [W8-1:0] r8_sum;
    logic [1:0]    r8_dbg;

    serial_add_sched #(.WIDTH(W8)) dut8 (
        .clk(clk), .clr(clr), .req0(r8_req0), .req1(r8_req1),
        .a0(r8_a0), .b0(r8_b0), .a1(r8_a1), .b1(r8_b1),
        .gnt0(r8_gnt0), .gnt1(r8_gnt1), .busy(r8_busy), .done(r8_done), .done_id(r8_done_id),
        .sum(r8_sum), .cout(r8_cout), .dbg_state(r8_dbg)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    logic       exp_id_q[$];
    int         exp_cyc_q[$];
    int         g_cyc_q[$];
    int         g_id_q[$];
    int         last_gnt = 1;

    always @(negedge clk) begin
        if (clr) begin
            if (gnt0 || gnt1) begin
                check("gnt_both_high", {31'd0, gnt0 & gnt1}, 32'd0);
                if (gnt0) begin
                    exp_q.push_back({1'b0, a0} + {1'b0, b0});
                    exp_id_q.push_back(1'b0);
                end else begin
                    exp_q.push_back({1'b0, a1} + {1'b0, b1});
                    exp_id_q.push_back(1'b1);
                end
                exp_cyc_q.push_back(cyc);
                last_gnt = gnt0 ? 0 : 1;
                g_cyc_q.push_back(cyc);
                g_id_q.push_back(gnt0 ? 0 : 1);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    logic [W:0] e;
                    logic       eid;
                    int         ec;
                    e   = exp_q.pop_front();
                    eid = exp_id_q.pop_front();
                    ec  = exp_cyc_q.pop_front();
                    check("sb_sum", {28'd0, sum}, {28'd0, e[W-1:0]});
                    check("sb_cout", {31'd0, cout}, {31'd0, e[W]});
                    check("sb_done_id", {31'd0, done_id}, {31'd0, eid});
                    check("sb_latency", cyc - ec, W);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || dbg_state != 2'd0) && k < 40) begin
            tick();
            k++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        k = 0;
        do begin
            tick();
            k++;
        end while (!(id ? gnt1 : gnt0) && k < 40);
        check("gnt_seen", {31'd0, id ? gnt1 : gnt0}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();
    endtask

    // Both clients held for four grant slots; expected order from a last-grant model.
    task automatic run_both();
        int first;
        g_cyc_q.delete();
        g_id_q.delete();
`ifdef SERIAL_ADD_SCHED_RR_EN
        first = (last_gnt == 1) ? 0 : 1;
`else
        first = 0;
`endif
        a0 = W'($urandom); b0 = W'($urandom);
        a1 = W'($urandom); b1 = W'($urandom);
        req0 = 1'b1;
        req1 = 1'b1;
        tick(24);
        req0 = 1'b0;
        req1 = 1'b0;
        check("both_grant_count", g_id_q.size(), 4);
        for (int i = 0; i < g_id_q.size(); i++) begin
`ifdef SERIAL_ADD_SCHED_RR_EN
            check("both_grant_id", g_id_q[i], (first + i) % 2);
`else
            check("both_grant_id", g_id_q[i], first);
`endif
            if (i > 0) check("both_grant_spacing", g_cyc_q[i] - g_cyc_q[i-1], 6);
        end
        wait_idle();
    endtask

    task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b);
        logic [W8:0] e;
        int k;
        e = {1'b0, a} + {1'b0, b};
        r8_a0 = a; r8_b0 = b; r8_req0 = 1'b1;
        tick();
        check("w8_gnt0", {31'd0, r8_gnt0}, 32'd1);
        r8_req0 = 1'b0;
        k = 0;
        while (!r8_done && k < 30) begin
            tick();
            k++;
        end
        check("w8_latency", k, W8);
        check("w8_sum", {24'd0, r8_sum}, {24'd0, e[W8-1:0]});
        check("w8_cout", {31'd0, r8_cout}, {31'd0, e[W8]});
        tick(2);
        check("w8_busy_low", {31'd0, r8_busy}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed / random sequence ----------------
    initial begin
        #12;
        check("reset_outputs", {24'd0, gnt0, gnt1, busy, done, done_id, cout, dbg_state}, 32'd0);
        check("reset_sum", {28'd0, sum}, 32'd0);
        check("reset_w8_outputs", {24'd0, r8_gnt0, r8_gnt1, r8_busy, r8_done, r8_done_id, r8_cout, r8_dbg}, 32'd0);
        clr = 1'b1;
        tick(2);

        // 4 + 1 with exact cycle-by-cycle handshake timing
        a0 = 4'b0100; b0 = 4'b0001; req0 = 1'b1;
        tick();
        check("t1_gnt0_e0", {30'd0, gnt0, gnt1}, 32'd2);
        check("t1_busy_e0", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        tick();
        check("t1_gnt0_drop", {31'd0, gnt0}, 32'd0);
        tick(2);
        check("t1_no_early_done", {31'd0, done}, 32'd0);
        tick();
        check("t1_done_e4", {31'd0, done}, 32'd1);
        check("t1_sum", {28'd0, sum}, 32'h5);
        check("t1_cout_id", {30'd0, cout, done_id}, 32'd0);
        tick();
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_busy_fall", {31'd0, busy}, 32'd0);

        // 15 + 1 from client 1 wraps with carry
        do_req(1'b1, 4'b1111, 4'b0001);
        check("t2_sum_held", {28'd0, sum}, 32'h0);
        check("t2_cout_id", {30'd0, cout, done_id}, 32'd3);

        for (int i = 0; i < 16; i++) begin
            do_req(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 3));
        end

        run_both();

        // late req1 waits until the edge after busy falls
        a0 = W'($urandom); b0 = W'($urandom); req0 = 1'b1;
        tick();
        check("late_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        tick(2);
        a1 = W'($urandom); b1 = W'($urandom); req1 = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            tick();
            check("late_gnt1_wait", {31'd0, gnt1}, 32'd0);
        end
        tick();
        check("late_gnt1_e6", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        wait_idle();
        check("late_done_id", {31'd0, done_id}, 32'd1);

        // async reset during the second SHIFT cycle
        do_req(1'b0, 4'b0111, 4'b0110);
        a0 = 4'b0011; b0 = 4'b0101; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick();
        #1 clr = 1'b0;
        #1;
        check("clr_ctrl", {25'd0, busy, done, gnt0, gnt1, done_id, dbg_state}, 32'd0);
        check("clr_sum_cout", {27'd0, cout, sum}, 32'd0);
        exp_q.delete();
        exp_id_q.delete();
        exp_cyc_q.delete();
        last_gnt = 1;
        #2 clr = 1'b1;
        tick(10);
        check("clr_quiet", {30'd0, busy, done}, 32'd0);

        run_both();
        do_req(1'b0, 4'b1001, 4'b1000);
        check("post_clr_sum", {27'd0, cout, sum}, 32'h11);

        run8(8'hFF, 8'h01);
        for (int i = 0; i < 3; i++) run8(W8'($urandom), W8'($urandom));

        tick(3);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
